imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 150 +++++++++++++++
 tb/tb_imem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction-RAM arbiter: serialises CPU fetches and program-loader writes
// onto a single 256x24 synchronous RAM port. Loader bytes are packed MSB-first
// into 24-bit words; ties between a fetch and a pending word alternate.
module imem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [7:0]  fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [23:0] fetch_data,
  input  logic        ld_start,
  input  logic        ld_byte_valid,
  input  logic [7:0]  ld_byte,
  output logic        ld_byte_ready,
  output logic [7:0]  ld_addr,
  output logic        ld_wrap,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [23:0] ram_wdata,
  input  logic [23:0] ram_rdata,
  input  logic        ram_ack
);

  typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWstrobe, StWack} state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_idx_q;
  logic [23:0] word_q;
  logic        word_pending_q;
  logic        fav_loader_q;  // 1: loader wins the next tie
  logic        restart_q;     // ld_start seen while a write was in flight
  logic [7:0]  ld_addr_q;
  logic        ld_wrap_q;
  logic        ram_we_q;
  logic [7:0]  ram_addr_q;
  logic [23:0] ram_wdata_q;
  logic        fetch_valid_q;
  logic [23:0] fetch_data_q;

  logic is_idle, in_write, fetch_go, load_go, byte_go, write_done;

  // Grant decode; fetch_ready deliberately ignores fetch_req
  always_comb begin
    is_idle       = (state_q == StIdle);
    in_write      = (state_q == StWstrobe) || (state_q == StWack);
    fetch_ready   = is_idle && !(word_pending_q && fav_loader_q);
    fetch_go      = fetch_ready && fetch_req;
    // A restart discards an ungranted word, so it also blocks its grant
    load_go       = is_idle && word_pending_q && !ld_start && !(fetch_req && !fav_loader_q);
    ld_byte_ready = !word_pending_q && !ld_start;
    byte_go       = ld_byte_valid && ld_byte_ready;
    write_done    = (state_q == StWack) && ram_ack;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (fetch_go)     state_d = StRaddr;
        else if (load_go) state_d = StWstrobe;
      end
      StRaddr:   state_d = StRdata;
      StRdata:   state_d = StIdle;
      StWstrobe: state_d = StWack;
      StWack:    if (ram_ack) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Byte assembler, loader address and wrap pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx_q     <= 2'd0;
      word_q         <= 24'd0;
      word_pending_q <= 1'b0;
      ld_addr_q      <= 8'd0;
      ld_wrap_q      <= 1'b0;
      restart_q      <= 1'b0;
    end else begin
      ld_wrap_q <= 1'b0;
      if (ld_start) begin
        byte_idx_q <= 2'd0;
        ld_addr_q  <= 8'd0;
        // A word already handed to the RAM must still finish its write
        if (!in_write) word_pending_q <= 1'b0;
      end else if (byte_go) begin
        case (byte_idx_q)
          2'd0:    word_q[23:16] <= ld_byte;
          2'd1:    word_q[15:8]  <= ld_byte;
          default: begin
            word_q[7:0]    <= ld_byte;
            word_pending_q <= 1'b1;
          end
        endcase
        byte_idx_q <= (byte_idx_q == 2'd2) ? 2'd0 : byte_idx_q + 2'd1;
      end
      if (write_done) begin
        word_pending_q <= 1'b0;
        restart_q      <= 1'b0;
        if (!ld_start && !restart_q) begin
          ld_addr_q <= ld_addr_q + 8'd1;
          ld_wrap_q <= (ld_addr_q == 8'hff);
        end
      end else if (ld_start && in_write) begin
        restart_q <= 1'b1;
      end
    end
  end

  // RAM port registers, fetch return path and round-robin flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q      <= 1'b0;
      ram_addr_q    <= 8'd0;
      ram_wdata_q   <= 24'd0;
      fetch_valid_q <= 1'b0;
      fetch_data_q  <= 24'd0;
      fav_loader_q  <= 1'b0;
    end else begin
      ram_we_q      <= load_go;
      fetch_valid_q <= (state_q == StRdata);
      if (state_q == StRdata) fetch_data_q <= ram_rdata;
      if (fetch_go) begin
        ram_addr_q   <= fetch_addr;
        fav_loader_q <= 1'b1;
      end else if (load_go) begin
        ram_addr_q   <= ld_addr_q;
        ram_wdata_q  <= word_q;
        fav_loader_q <= 1'b0;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = fetch_data_q;
  assign ld_addr     = ld_addr_q;
  assign ld_wrap     = ld_wrap_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a transaction-level model (byte queue, busy
// counters, shadow memory) predicts every output each cycle; directed
// scenarios add literal expectations; a random phase exercises the rest.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, fetch_req, ld_start, ld_byte_valid;
  logic [7:0]  fetch_addr, ld_byte;
  logic        fetch_ready, fetch_valid, ld_byte_ready, ld_wrap, ram_we, ram_ack;
  logic [23:0] fetch_data, ram_wdata, ram_rdata;
  logic [7:0]  ld_addr, ram_addr;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte),
    .ld_byte_ready(ld_byte_ready), .ld_addr(ld_addr), .ld_wrap(ld_wrap),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  // Synchronous RAM with one-cycle write acknowledge
  logic [23:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    ram_ack   <= ram_we;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [23:0] exp_mem [256];
  logic [7:0]  m_bytes[$];
  int          m_fetch_left;  // cycles until the read returns
  int          m_wstage;      // 0 none, 1 strobe cycle, 2 awaiting ack
  bit          m_pending, m_fav_loader, m_restart, m_fv, m_wrap;
  logic [23:0] m_fd, m_wdata, m_word;
  logic [7:0]  m_raddr, m_ld_addr;

  bit          s_ack, acc, log_en;
  int          wrap_cnt;
  logic [7:0]  glog[$];

  function automatic bit m_idle();
    return (m_fetch_left == 0) && (m_wstage == 0);
  endfunction

  function automatic bit m_fetch_ready();
    return m_idle() && !(m_pending && m_fav_loader);
  endfunction

  function automatic void model_reset();
    m_fetch_left = 0; m_wstage = 0; m_pending = 0; m_fav_loader = 0; m_restart = 0;
    m_fv = 0; m_wrap = 0; m_fd = '0; m_wdata = '0; m_word = '0; m_raddr = '0;
    m_ld_addr = '0;
    m_bytes.delete();
  endfunction

  function automatic void model_step();
    bit         idle     = m_idle();
    bit         in_write = (m_wstage != 0);
    bit         grant_f  = m_fetch_ready() && fetch_req;
    bit         grant_l  = idle && m_pending && !ld_start && (!fetch_req || m_fav_loader);
    bit         byte_ok  = ld_byte_valid && !m_pending && !ld_start;
    logic [7:0] waddr    = m_ld_addr;
    m_fv   = 0;
    m_wrap = 0;
    if (m_fetch_left == 1) begin
      m_fv = 1;
      m_fd = exp_mem[m_raddr];
    end
    if (m_fetch_left > 0) m_fetch_left--;
    if (ld_start) begin
      m_bytes.delete();
      m_ld_addr = 0;
      if (in_write) m_restart = 1;
      else          m_pending = 0;
    end
    if (m_wstage == 1) m_wstage = 2;
    else if (m_wstage == 2 && s_ack) begin
      m_pending = 0;
      if (ld_start || m_restart) m_ld_addr = 0;
      else begin
        m_wrap = (m_ld_addr == 8'hff);
        m_ld_addr = m_ld_addr + 8'd1;
      end
      m_restart = 0;
      m_wstage  = 0;
    end
    if (byte_ok) begin
      m_bytes.push_back(ld_byte);
      if (m_bytes.size() == 3) begin
        m_word = {m_bytes[0], m_bytes[1], m_bytes[2]};
        m_pending = 1;
        m_bytes.delete();
      end
    end
    if (grant_f) begin
      m_raddr = fetch_addr; m_fetch_left = 2; m_fav_loader = 1;
    end
    if (grant_l) begin
      m_raddr = waddr; m_wdata = m_word; exp_mem[waddr] = m_word;
      m_wstage = 1; m_fav_loader = 0;
    end
  endfunction

  // One clock: compare at negedge+1, advance model at posedge, return at negedge
  task automatic tick();
    #1;
    chk("fetch_ready", fetch_ready, m_fetch_ready());
    chk("ld_byte_ready", ld_byte_ready, !m_pending && !ld_start);
    chk("fetch_valid", fetch_valid, m_fv);
    chk("fetch_data", fetch_data, m_fd);
    chk("ram_we", ram_we, m_wstage == 1);
    chk("ram_addr", ram_addr, m_raddr);
    chk("ram_wdata", ram_wdata, m_wdata);
    chk("ld_addr", ld_addr, m_ld_addr);
    chk("ld_wrap", ld_wrap, m_wrap);
    s_ack = ram_ack;
    acc   = ld_byte_valid && ld_byte_ready;
    if (ld_wrap) wrap_cnt++;
    if (log_en) begin
      if (fetch_req && fetch_ready) glog.push_back("F");
      if (ram_we) glog.push_back("L");
    end
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] b);
    bit got = 0;
    ld_byte = b;
    ld_byte_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = acc;
    end
    ld_byte_valid = 1'b0;
    chk("byte_accept", got, 1);
  endtask

  task automatic feed_word(input logic [23:0] w);
    feed(w[23:16]);
    feed(w[15:8]);
    feed(w[7:0]);
  endtask

  task automatic wait_we();
    int n = 0;
    while (ram_we !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ram_we_wait", ram_we, 1);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  initial begin
    logic [31:0] seq;
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; ld_start = 1'b0;
    ld_byte_valid = 1'b0; ld_byte = '0; log_en = 0; wrap_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (24'(i) * 24'h010203) ^ 24'h5a5a5a;
      exp_mem[i] = (24'(i) * 24'h010203) ^ 24'h5a5a5a;
    end
    model_reset();
    @(negedge clk);
    tick();
    tick();
    chk("rst_fetch_ready", fetch_ready, 1);
    chk("rst_ld_byte_ready", ld_byte_ready, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ld_addr", ld_addr, 0);
    rst_n = 1'b1;

    // Single word load, then read it back
    pulse_start();
    feed_word(24'h123456);
    wait_we();
    chk("load_ram_addr", ram_addr, 8'h00);
    chk("load_ram_wdata", ram_wdata, 24'h123456);
    tick();
    tick();
    chk("load_ld_addr", ld_addr, 8'h01);
    fetch_req = 1'b1; fetch_addr = 8'h00;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    chk("fetch_valid_n3", fetch_valid, 1);
    chk("fetch_data_n3", fetch_data, 24'h123456);

    // Reset while a fetch is in RADDR
    fetch_req = 1'b1; fetch_addr = 8'h10;
    tick();
    fetch_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_fetch_valid", fetch_valid, 0);
    chk("abort_fetch_data", fetch_data, 0);
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_wdata", ram_wdata, 0);
    chk("abort_ld_addr", ld_addr, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // Competing fetch and loader: grants must alternate
    glog.delete();
    log_en = 1; fetch_req = 1'b1; fetch_addr = 8'h22; ld_byte_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ld_byte = 8'(i + 8'h40);
      tick();
    end
    fetch_req = 1'b0; ld_byte_valid = 1'b0; log_en = 0;
    repeat (6) tick();
    seq = '0;
    for (int i = 0; i < 4 && i < glog.size(); i++) seq = {seq[23:0], glog[i]};
    chk("grant_order", seq, 32'h464C464C);

    // Restart during WACK of the word at address 5; then partial-word discard
    pulse_start();
    wrap_cnt = 0;
    for (int w = 0; w < 5; w++) feed_word(24'(w) * 24'h111111);
    feed_word(24'hc0ffee);
    wait_we();
    chk("wack_ram_addr", ram_addr, 8'h05);
    tick();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("wack_start_ld_addr", ld_addr, 8'h00);
    chk("wack_mem5", mem[5], 24'hc0ffee);
    tick();
    chk("wack_no_wrap", wrap_cnt, 0);
    feed(8'h77);
    feed(8'h88);
    pulse_start();
    feed_word(24'habcdef);
    wait_we();
    chk("partial_ram_addr", ram_addr, 8'h00);
    chk("partial_ram_wdata", ram_wdata, 24'habcdef);
    repeat (3) tick();

    // 256 words wrap the address exactly once; the 257th lands at 0
    pulse_start();
    wrap_cnt = 0;
    for (int w = 0; w < 256; w++) feed_word(24'($urandom));
    repeat (5) tick();
    chk("wrap_count", wrap_cnt, 1);
    chk("wrap_ld_addr", ld_addr, 8'h00);
    feed_word(24'h5a0257);
    wait_we();
    chk("word257_addr", ram_addr, 8'h00);
    repeat (3) tick();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      fetch_req     = 1'($urandom_range(0, 1));
      fetch_addr    = 8'($urandom);
      ld_byte_valid = 1'($urandom_range(0, 1));
      ld_byte       = 8'($urandom);
      ld_start      = ($urandom_range(0, 31) == 0);
      tick();
    end
    fetch_req = 1'b0; ld_byte_valid = 1'b0; ld_start = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
